// File: rtl/cas_cla_stage_pkg.sv
// ---------------------------------------------------------------------------
// cas_cla_stage_pkg
//   Shared constants and helpers for the pipelined compare-and-swap element.
//   - CAS_GROUP_W    : bit width of one carry-lookahead group.
//   - CAS_ASC/DESC   : values for the DESCENDING parameter of cas_cla_stage.
//   - cas_width_ok() : legality check for the operand width.
// ---------------------------------------------------------------------------
package cas_cla_stage_pkg;

  localparam int CAS_GROUP_W = 4;

  localparam bit CAS_ASC  = 1'b0;
  localparam bit CAS_DESC = 1'b1;

  // Legal widths are whole lookahead groups between 4 and 32 bits.
  function automatic bit cas_width_ok(input int width);
    return (width >= 4) && (width <= 32) && ((width % CAS_GROUP_W) == 0);
  endfunction

endpackage

// File: rtl/cas_cla_stage_cla_group_unit.sv
// ---------------------------------------------------------------------------
// cla_group_unit
//   Combinational 4-bit carry-lookahead group. Used both for bit-level groups
//   (g/p are per-bit generate/propagate) and for the second lookahead level
//   (g/p are per-group G/P).
// Ports:
//   g   [3:0]  generate inputs
//   p   [3:0]  propagate inputs
//   cin        carry into position 0
//   c   [3:1]  carries into positions 1..3
//   gg         group generate
//   gp         group propagate
// ---------------------------------------------------------------------------
module cla_group_unit
  import cas_cla_stage_pkg::*;
(
  input  logic [CAS_GROUP_W-1:0] g,
  input  logic [CAS_GROUP_W-1:0] p,
  input  logic                   cin,
  output logic [CAS_GROUP_W-1:1] c,
  output logic                   gg,
  output logic                   gp
);

  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
  assign gp = &p;

endmodule

// File: rtl/cas_cla_stage.sv
// ---------------------------------------------------------------------------
// cas_cla_stage
//   Two-stage pipelined compare-and-swap element for the pixel sorting
//   network. Stage 1 registers the operands with bitwise generate/propagate
//   of A + ~B + 1; stage 2 resolves the carry-out through two levels of
//   4-bit lookahead (ge = A >= B) and registers the ordered pair.
// Parameters:
//   WIDTH       operand width, multiple of 4 in 4..32
//   DESCENDING  CAS_ASC: smaller operand on out_lo; CAS_DESC: larger on out_lo
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   in_valid/in_ready        upstream handshake, in_a/in_b operands
//   out_valid/out_ready      downstream handshake
//   out_lo/out_hi            ordered operands
//   out_swapped              operands were exchanged relative to (A,B)
//   swap_count [31:0]        only with CAS_STATS_EN defined: saturating count
//                            of swapped output transfers
// ---------------------------------------------------------------------------
module cas_cla_stage
  import cas_cla_stage_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter bit DESCENDING = CAS_ASC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_lo,
  output logic [WIDTH-1:0] out_hi,
  output logic             out_swapped
`ifdef CAS_STATS_EN
  ,
  output logic [31:0]      swap_count
`endif
);

  if (!cas_width_ok(WIDTH)) begin : g_width_check
    $error("cas_cla_stage: WIDTH must be a multiple of 4 in 4..32");
  end

  localparam int NUM_GRP     = WIDTH / CAS_GROUP_W;
  localparam int NUM_SL      = (NUM_GRP + CAS_GROUP_W - 1) / CAS_GROUP_W;
  localparam int NUM_GRP_PAD = NUM_SL * CAS_GROUP_W;

  // Stage 1 registers
  logic             v1_q, v1_d;
  logic [WIDTH-1:0] a1_q, a1_d;
  logic [WIDTH-1:0] b1_q, b1_d;
  logic [WIDTH-1:0] g1_q, g1_d;
  logic [WIDTH-1:0] p1_q, p1_d;

  // Stage 2 registers
  logic             out_valid_q,   out_valid_d;
  logic [WIDTH-1:0] out_lo_q,      out_lo_d;
  logic [WIDTH-1:0] out_hi_q,      out_hi_d;
  logic             out_swapped_q, out_swapped_d;

  logic adv1, adv2;
  logic ge, eq, swap;

  assign adv2     = ~out_valid_q | out_ready;
  assign adv1     = ~v1_q | adv2;
  assign in_ready = adv1;

  // NOTE: every combinational output gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    v1_d = v1_q;
    a1_d = a1_q;
    b1_d = b1_q;
    g1_d = g1_q;
    p1_d = p1_q;
    if (adv1) begin
      v1_d = in_valid;
      if (in_valid) begin
        a1_d = in_a;
        b1_d = in_b;
        g1_d = in_a & ~in_b;
        p1_d = in_a ^ ~in_b;
      end
    end
  end

  // ---- Carry resolution ---------------------------------------------------
  logic [NUM_GRP_PAD-1:0] grp_g, grp_p;   // per-group G/P, padded transparent
  logic [NUM_GRP_PAD-1:0] grp_c;          // carry into each group
  logic [NUM_SL-1:0]      sl_g, sl_p, sl_cin;
  logic [3*NUM_GRP-1:0]   unused_bit_c;   // bit carries: only the carry-out matters

  for (genvar i = 0; i < NUM_GRP; i++) begin : g_lvl1
    cla_group_unit u_grp (
      .g   (g1_q[CAS_GROUP_W*i +: CAS_GROUP_W]),
      .p   (p1_q[CAS_GROUP_W*i +: CAS_GROUP_W]),
      .cin (grp_c[i]),
      .c   (unused_bit_c[3*i +: 3]),
      .gg  (grp_g[i]),
      .gp  (grp_p[i])
    );
  end

  // Unused group slots pass their carry straight through.
  for (genvar i = NUM_GRP; i < NUM_GRP_PAD; i++) begin : g_pad
    assign grp_g[i] = 1'b0;
    assign grp_p[i] = 1'b1;
  end

  for (genvar s = 0; s < NUM_SL; s++) begin : g_lvl2
    assign grp_c[CAS_GROUP_W*s] = sl_cin[s];
    cla_group_unit u_sl (
      .g   (grp_g[CAS_GROUP_W*s +: CAS_GROUP_W]),
      .p   (grp_p[CAS_GROUP_W*s +: CAS_GROUP_W]),
      .cin (sl_cin[s]),
      .c   (grp_c[CAS_GROUP_W*s+1 +: CAS_GROUP_W-1]),
      .gg  (sl_g[s]),
      .gp  (sl_p[s])
    );
  end

  // Second-level groups are chained; carry-in of the subtraction is 1.
  always_comb begin
    logic carry;
    carry = 1'b1;
    for (int s = 0; s < NUM_SL; s++) begin
      sl_cin[s] = carry;
      carry     = sl_g[s] | (sl_p[s] & carry);
    end
    ge = carry;
  end

  assign eq   = &p1_q;
  assign swap = (DESCENDING == CAS_DESC) ? ~ge : (ge & ~eq);

  always_comb begin
    out_valid_d   = out_valid_q;
    out_lo_d      = out_lo_q;
    out_hi_d      = out_hi_q;
    out_swapped_d = out_swapped_q;
    if (adv2) begin
      out_valid_d = v1_q;
      if (v1_q) begin
        out_lo_d      = swap ? b1_q : a1_q;
        out_hi_d      = swap ? a1_q : b1_q;
        out_swapped_d = swap;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q          <= 1'b0;
      a1_q          <= '0;
      b1_q          <= '0;
      g1_q          <= '0;
      p1_q          <= '0;
      out_valid_q   <= 1'b0;
      out_lo_q      <= '0;
      out_hi_q      <= '0;
      out_swapped_q <= 1'b0;
    end else begin
      v1_q          <= v1_d;
      a1_q          <= a1_d;
      b1_q          <= b1_d;
      g1_q          <= g1_d;
      p1_q          <= p1_d;
      out_valid_q   <= out_valid_d;
      out_lo_q      <= out_lo_d;
      out_hi_q      <= out_hi_d;
      out_swapped_q <= out_swapped_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_lo      = out_lo_q;
  assign out_hi      = out_hi_q;
  assign out_swapped = out_swapped_q;

`ifdef CAS_STATS_EN
  logic [31:0] swap_count_q, swap_count_d;

  always_comb begin
    swap_count_d = swap_count_q;
    if (out_valid_q && out_ready && out_swapped_q && (swap_count_q != '1)) begin
      swap_count_d = swap_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) swap_count_q <= '0;
    else     swap_count_q <= swap_count_d;
  end

  assign swap_count = swap_count_q;
`endif

endmodule
